// File: rtl/div_serial_pkg.sv
// Shared encodings for the serial divider: FSM states and handshake levels.
package div_serial_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResReady    = 1'b1;
  localparam logic DivResNotReady = 1'b0;
  localparam logic DivStart       = 1'b1;
  localparam logic DivStop        = 1'b0;

endpackage

// File: rtl/div_serial_iter.sv
// One restoring-division step: shift {rem,quot} left, subtract the divisor from
// the partial remainder and keep the difference when it does not go negative.
module div_serial_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [2*WIDTH:0] dividend_o
);

  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   trial;

  // Partial remainder is always < divisor, so after the shift it fits WIDTH+1 bits.
  always_comb begin
    shifted = dividend_i << 1;
    trial   = shifted[2*WIDTH:WIDTH] - {1'b0, divisor_i};
    if (!trial[WIDTH]) begin
      dividend_o = {trial, shifted[WIDTH-1:1], 1'b1};
    end else begin
      dividend_o = shifted;
    end
  end

endmodule

// File: rtl/div_serial.sv
// Multi-cycle radix-2 restoring divider answering the EX-stage divide handshake.
// Returns {remainder, quotient}; signed mode divides magnitudes and fixes signs
// at the end. Optional macro DIV_ZERO_FLAG_EN adds the divzero_o status port.
module div_serial
  import div_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   op1_i,
  input  logic [WIDTH-1:0]   op2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic               divzero_o
`endif
);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   dividend_q, dividend_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic               signed_q, signed_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;
  logic               divzero_q, divzero_d;

  logic [WIDTH-1:0]   op1_abs, op2_abs;
  logic [2*WIDTH:0]   step_next;
  logic [WIDTH-1:0]   quot_raw, rem_raw, quot_fin, rem_fin;

  div_serial_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .dividend_i (dividend_q),
    .divisor_i  (divisor_q),
    .dividend_o (step_next)
  );

  // Operand magnitudes and final sign correction of the quotient/remainder.
  always_comb begin
    op1_abs  = (signed_div_i && op1_i[WIDTH-1]) ? (~op1_i + 1'b1) : op1_i;
    op2_abs  = (signed_div_i && op2_i[WIDTH-1]) ? (~op2_i + 1'b1) : op2_i;
    quot_raw = dividend_q[WIDTH-1:0];
    rem_raw  = dividend_q[2*WIDTH-1:WIDTH];
    quot_fin = (signed_q && (s1_q ^ s2_q)) ? (~quot_raw + 1'b1) : quot_raw;
    rem_fin  = (signed_q && s1_q) ? (~rem_raw + 1'b1) : rem_raw;
  end

  // Next-state and registered-output logic of the divide FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    signed_d   = signed_q;
    result_d   = result_q;
    ready_d    = ready_q;
    divzero_d  = divzero_q;
    unique case (state_q)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          if (op2_i == '0) begin
            state_d = DivByZero;
          end else begin
            divisor_d  = op2_abs;
            s1_d       = op1_i[WIDTH-1];
            s2_d       = op2_i[WIDTH-1];
            signed_d   = signed_div_i;
            dividend_d = {{(WIDTH + 1){1'b0}}, op1_abs};
            cnt_d      = '0;
            state_d    = DivOn;
          end
        end
      end
      DivByZero: begin
        result_d  = '0;
        ready_d   = DivResReady;
        divzero_d = 1'b1;
        state_d   = DivEnd;
      end
      DivOn: begin
        if (annul_i) begin
          cnt_d   = '0;
          ready_d = DivResNotReady;
          state_d = DivFree;
        end else if (cnt_q != CNT_W'(WIDTH)) begin
          dividend_d = step_next;
          cnt_d      = cnt_q + 1'b1;
        end else begin
          result_d = {rem_fin, quot_fin};
          ready_d  = DivResReady;
          state_d  = DivEnd;
        end
      end
      DivEnd: begin
        // Result is held for EX until it withdraws the request.
        if (start_i == DivStop) begin
          result_d  = '0;
          ready_d   = DivResNotReady;
          divzero_d = 1'b0;
          state_d   = DivFree;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      signed_q   <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResNotReady;
      divzero_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      signed_q   <= signed_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      divzero_q  <= divzero_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
`ifdef DIV_ZERO_FLAG_EN
  assign divzero_o = divzero_q;
`else
  logic unused_divzero;
  assign unused_divzero = divzero_q;
`endif

endmodule

// File: tb/tb_div_serial.sv
// Scoreboard bench for div_serial: expected results are queued when a divide is
// launched and compared when ready_o rises. Also covers latency, hold, annul and reset.
module tb_div_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] op1_i, op2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o;
`ifdef DIV_ZERO_FLAG_EN
  logic        divzero_o;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [64:0] sb_q[$];  // {divzero, result}

  div_serial #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .op1_i        (op1_i),
    .op2_i        (op2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .divzero_o    (divzero_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sg);
    logic        n1, n2;
    logic [31:0] ua, ub, q, r;
    if (b == 32'd0) return 64'd0;
    n1 = sg && a[31];
    n2 = sg && b[31];
    ua = n1 ? -a : a;
    ub = n2 ? -b : b;
    q  = ua / ub;
    r  = ua % ub;
    if (n1 ^ n2) q = -q;
    if (n1) r = -r;
    return {r, q};
  endfunction

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sg, input logic [63:0] exp, input int hold);
    int          cycles;
    logic [64:0] e;
    sb_q.push_back({(b == 32'd0), exp});
    @(negedge clk);
    op1_i = a;
    op2_i = b;
    signed_div_i = sg;
    start_i = 1'b1;
    annul_i = 1'b0;
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      // Operands must be ignored once the request is taken.
      op1_i = $urandom;
      op2_i = $urandom;
      signed_div_i = 1'($urandom);
    end while (!ready_o && cycles < 100);
    check_eq({tag, "_lat"}, 64'(cycles), (b == 32'd0) ? 64'd2 : 64'd34);
    e = sb_q.pop_front();
    check_eq({tag, "_res"}, result_o, e[63:0]);
`ifdef DIV_ZERO_FLAG_EN
    check_eq({tag, "_dz"}, 64'(divzero_o), 64'(e[64]));
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq({tag, "_hold"}, {result_o[62:0], ready_o} ^ {e[62:0], 1'b1}, 64'd0);
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, "_drop"}, {63'(result_o), ready_o}, 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        sg;
    int          highs;
    rst = 1'b0;
    signed_div_i = 1'b0;
    op1_i = '0;
    op2_i = '0;
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_result", result_o, 64'd0);
    check_eq("rst_ready", 64'(ready_o), 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    check_eq("rst_dz", 64'(divzero_o), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    run_div("u100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 5);
    run_div("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1);
    run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 1);
    run_div("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0}, 1);
    run_div("div0", 32'd1234, 32'd0, 1'b0, 64'd0, 1);
    run_div("u_small", 32'd5, 32'd9, 1'b0, {32'd5, 32'd0}, 0);
    run_div("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 0);

    // Annul in the middle of DivOn: the abandoned result must never appear.
    @(negedge clk);
    op1_i = 32'd100;
    op2_i = 32'd7;
    signed_div_i = 1'b0;
    start_i = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    highs = 0;
    @(posedge clk);
    #1;
    if (ready_o) highs++;
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    if (ready_o) highs++;
    check_eq("annul_noready", 64'(highs), 64'd0);
    run_div("after_annul", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 0);

    // Synchronous reset in the middle of a divide.
    @(negedge clk);
    op1_i = 32'd100;
    op2_i = 32'd7;
    start_i = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_out", {63'(result_o), ready_o}, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    check_eq("midrst_dz", 64'(divzero_o), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    start_i = 1'b0;
    run_div("after_rst", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 0);

    // Random operands against the reference model.
    for (int i = 0; i < 8; i++) begin
      a  = $urandom;
      b  = (i < 4) ? 32'($urandom_range(1, 300)) : $urandom;
      sg = 1'(i % 2);
      if (i == 2) a = -a;
      run_div("rand", a, b, sg, model(a, b, sg), 0);
    end

    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
